psum_tile_buffer: RTL and testbench
===================================

// Module: psum_tile_buffer
// PURPOSE
//  Partial-sum store/replay engine feeding the strategy-2 accumulator across input-channel tiles.
//  Captures each finished accumulator result of tile t, then on tile t+1 replays it to the
//  accumulator as the Psum-from-last-tile operand, with the one-cycle load strobe.
//  First tile replays zeros. Last tile diverts results to the final output stream instead of storing.
// PARAMETERS
//  DEPTH   64  max output elements per tile (buffer entries)
//  ADDR_W  6   log2(DEPTH)
//  PSUM_W  32  partial-sum width (two's complement)
// PORTS
//  i_clk             in   1       clock, rising edge
//  i_rst_n           in   1       asynchronous, active-low reset
//  i_tile_start      in   1       pulse: begin a tile; samples len/first/last
//  i_tile_len        in   ADDR_W+1 elements in tile, 1..DEPTH
//  i_first_tile      in   1       tile has no predecessor: replay zeros
//  i_last_tile       in   1       results go to o_final_*, not to buffer
//  i_psum_req        in   1       request replay of next element (in order 0..len-1)
//  o_psum_from_last_tile out PSUM_W replay data, valid when o_accumulation=1
//  o_accumulation    out  1       one-cycle load strobe to accumulator Psum register
//  i_result_valid    in   1       accumulator result valid (in order 0..len-1)
//  i_result          in   PSUM_W  accumulator result (o_result_strategy2)
//  o_final_valid     out  1       final result valid (last tile only), 1-cycle pulse
//  o_final_data      out  PSUM_W  final result
//  o_busy            out  1       FSM not IDLE
//  o_err             out  1       sticky protocol error, cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; rd_ptr=wr_ptr=0; buffer contents undefined (never read pre-write).
//  FSM: IDLE -(i_tile_start)-> ACTIVE -(rd_ptr==len && wr_ptr<len)-> DRAIN -(wr_ptr==len)-> IDLE.
//   ACTIVE -> IDLE directly when rd_ptr==len and wr_ptr==len in same cycle.
//  Tile start: latch len/first/last, zero rd_ptr/wr_ptr, o_busy=1 next cycle.
//   len=0 or len>DEPTH: start ignored, o_err set, stay IDLE.
//   i_tile_start while busy: ignored, o_err set, current tile continues.
//  Replay: i_psum_req in ACTIVE with rd_ptr<len -> next cycle o_accumulation=1,
//   o_psum_from_last_tile = first ? 0 : mem[rd_ptr]; rd_ptr++. Fixed latency 1; back-to-back OK.
//   o_accumulation=0 otherwise; o_psum_from_last_tile holds last value when strobe low.
//   i_psum_req when rd_ptr==len, in DRAIN, or in IDLE: ignored, o_err set.
//  Write-back: i_result_valid in ACTIVE/DRAIN with wr_ptr<len:
//   not last tile -> mem[wr_ptr]<=i_result; last tile -> o_final_valid=1,
//   o_final_data=i_result next cycle, buffer untouched. wr_ptr++.
//   i_result_valid with wr_ptr==len or in IDLE: dropped, o_err set.
//  Hazard: wr_ptr must not exceed rd_ptr; if i_result_valid arrives with wr_ptr==rd_ptr: dropped, o_err.
//  Same-cycle read and write to same address (possible only across tile boundary, never in-tile):
//   in-tile read index always >= write index; dual-port memory, read-old semantics not required.
//  Arithmetic: none; data passed bit-exact, PSUM_W wide, no sign change.
//  Reset mid-tile: immediate return to IDLE, pointers 0, strobes low; stored psums invalid,
//   next tile must be flagged first.
// CONFIGURATION
//  PSUM_PARITY_EN defined: each entry stores extra even-parity bit over PSUM_W data;
//   on replay (non-first tile) parity mismatch sets o_err in same cycle as o_accumulation;
//   data still delivered unmodified. Adds input port i_inj_parity_err (1 b): when 1
//   during write, stored parity bit inverted (test hook).
//  Not defined: no parity storage, no i_inj_parity_err port, o_err from protocol errors only.
// TESTING
//  First tile len=4, req x4 -> 4 strobes, psum=0 each, 1-cycle latency; results 10,-20,30,-40 stored.
//  Second tile len=4, not first -> replay 10,-20,30,-40 in order; results 11,22,33,44 stored.
//  Last tile len=4 after above -> replay 11,22,33,44; results 5,6,7,8 -> o_final_valid x4, data 5..8, buffer unchanged.
//  len=64 back-to-back reqs each cycle -> 64 consecutive strobes, FSM ACTIVE->DRAIN->IDLE, o_err=0.
//  Errors: start with len=0 -> o_err=1; 5th req on len=4 -> no strobe, o_err=1; start while busy -> ignored.
//  Reset asserted after 2 of 4 replays -> all outputs 0, o_busy=0 next edge; PSUM_PARITY_EN: inject on entry 1 -> o_err on its replay.

Source files
------------

// File: rtl/psum_tile_buffer.sv
// Partial-sum store/replay buffer between input-channel tiles of the strategy-2 accumulator.
// Optional PSUM_PARITY_EN: per-entry even parity with an injection hook (i_inj_parity_err).
module psum_tile_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int PSUM_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tile_start,
  input  logic [ADDR_W:0]   i_tile_len,
  input  logic              i_first_tile,
  input  logic              i_last_tile,
  input  logic              i_psum_req,
  output logic [PSUM_W-1:0] o_psum_from_last_tile,
  output logic              o_accumulation,
  input  logic              i_result_valid,
  input  logic [PSUM_W-1:0] i_result,
  output logic              o_final_valid,
  output logic [PSUM_W-1:0] o_final_data,
  output logic              o_busy,
`ifdef PSUM_PARITY_EN
  input  logic              i_inj_parity_err,
`endif
  output logic              o_err
);

  // state  | meaning
  // IDLE   | no tile open, waiting for i_tile_start
  // ACTIVE | replays outstanding, write-backs accepted
  // DRAIN  | all replays issued, waiting for remaining write-backs

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

  localparam int PTR_W = ADDR_W + 1;
`ifdef PSUM_PARITY_EN
  localparam int MEM_W = PSUM_W + 1;
`else
  localparam int MEM_W = PSUM_W;
`endif

  state_e            state;
  logic [ADDR_W:0]   len_q, rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic              first_q, last_q;
  logic              len_ok, start_ok, start_bad;
  logic              rd_ok, rd_bad, wr_ok, wr_bad, par_bad, err_evt;
  logic [MEM_W-1:0]  mem [DEPTH];
  logic [MEM_W-1:0]  rd_word, wr_word;

  assign len_ok    = (i_tile_len != '0) && (i_tile_len <= PTR_W'(DEPTH));
  assign start_ok  = i_tile_start && (state == IDLE) && len_ok;
  assign start_bad = i_tile_start && !start_ok;

  assign rd_ok  = i_psum_req && (state == ACTIVE) && (rd_ptr < len_q);
  assign rd_bad = i_psum_req && !rd_ok;
  // a result can only follow its own replay, hence wr_ptr < rd_ptr
  assign wr_ok  = i_result_valid && (state != IDLE) && (wr_ptr < len_q) && (wr_ptr < rd_ptr);
  assign wr_bad = i_result_valid && !wr_ok;

  assign rd_nxt  = rd_ptr + PTR_W'(rd_ok);
  assign wr_nxt  = wr_ptr + PTR_W'(wr_ok);
  assign rd_word = mem[rd_ptr[ADDR_W-1:0]];

`ifdef PSUM_PARITY_EN
  assign wr_word = {(^i_result) ^ i_inj_parity_err, i_result};
  assign par_bad = rd_ok && !first_q && ((^rd_word[PSUM_W-1:0]) != rd_word[PSUM_W]);
`else
  assign wr_word = i_result;
  assign par_bad = 1'b0;
`endif

  assign err_evt = start_bad | rd_bad | wr_bad | par_bad;

  always_ff @(posedge i_clk) begin
    if (wr_ok && !last_q) mem[wr_ptr[ADDR_W-1:0]] <= wr_word;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                 <= IDLE;
      len_q                 <= '0;
      rd_ptr                <= '0;
      wr_ptr                <= '0;
      first_q               <= 1'b0;
      last_q                <= 1'b0;
      o_psum_from_last_tile <= '0;
      o_accumulation        <= 1'b0;
      o_final_valid         <= 1'b0;
      o_final_data          <= '0;
      o_busy                <= 1'b0;
      o_err                 <= 1'b0;
    end else begin
      o_accumulation <= rd_ok;
      if (rd_ok) o_psum_from_last_tile <= first_q ? '0 : rd_word[PSUM_W-1:0];
      o_final_valid <= wr_ok && last_q;
      if (wr_ok && last_q) o_final_data <= i_result;
      if (err_evt) o_err <= 1'b1;

      case (state)
        IDLE: begin
          if (start_ok) begin
            state   <= ACTIVE;
            len_q   <= i_tile_len;
            first_q <= i_first_tile;
            last_q  <= i_last_tile;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            o_busy  <= 1'b1;
          end
        end
        ACTIVE: begin
          rd_ptr <= rd_nxt;
          wr_ptr <= wr_nxt;
          if (rd_nxt == len_q) begin
            if (wr_nxt == len_q) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          wr_ptr <= wr_nxt;
          if (wr_nxt == len_q) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_tile_buffer.sv
// Directed self-checking bench for psum_tile_buffer: tile replay chain, back-to-back, errors, reset.
module tb_psum_tile_buffer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_tile_start;
  logic [6:0]  i_tile_len;
  logic        i_first_tile;
  logic        i_last_tile;
  logic        i_psum_req;
  logic [31:0] o_psum_from_last_tile;
  logic        o_accumulation;
  logic        i_result_valid;
  logic [31:0] i_result;
  logic        o_final_valid;
  logic [31:0] o_final_data;
  logic        o_busy;
  logic        o_err;
`ifdef PSUM_PARITY_EN
  logic        i_inj_parity_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  psum_tile_buffer dut (
    .i_clk                 (i_clk),
    .i_rst_n               (i_rst_n),
    .i_tile_start          (i_tile_start),
    .i_tile_len            (i_tile_len),
    .i_first_tile          (i_first_tile),
    .i_last_tile           (i_last_tile),
    .i_psum_req            (i_psum_req),
    .o_psum_from_last_tile (o_psum_from_last_tile),
    .o_accumulation        (o_accumulation),
    .i_result_valid        (i_result_valid),
    .i_result              (i_result),
    .o_final_valid         (o_final_valid),
    .o_final_data          (o_final_data),
    .o_busy                (o_busy),
`ifdef PSUM_PARITY_EN
    .i_inj_parity_err      (i_inj_parity_err),
`endif
    .o_err                 (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic start_tile(input int n, input logic first, input logic last);
    i_tile_start = 1'b1;
    i_tile_len   = 7'(n);
    i_first_tile = first;
    i_last_tile  = last;
    tick();
    i_tile_start = 1'b0;
    check("busy_after_start", 32'(o_busy), 32'd1);
  endtask

  // one replay then its write-back per element
  task automatic run_tile(input logic first, input logic last,
                          input logic [31:0] exp_p[4], input logic [31:0] res[4]);
    start_tile(4, first, last);
    for (int i = 0; i < 4; i++) begin
      i_psum_req = 1'b1;
      tick();
      i_psum_req = 1'b0;
      check("strobe", 32'(o_accumulation), 32'd1);
      check("psum", o_psum_from_last_tile, exp_p[i]);
      i_result_valid = 1'b1;
      i_result       = res[i];
      tick();
      i_result_valid = 1'b0;
      check("strobe_low", 32'(o_accumulation), 32'd0);
      check("final_valid", 32'(o_final_valid), 32'(last));
      if (last) check("final_data", o_final_data, res[i]);
    end
    check("busy_end", 32'(o_busy), 32'd0);
    check("err_clean", 32'(o_err), 32'd0);
  endtask

  initial begin
    logic [31:0] zeros[4] = '{0, 0, 0, 0};
    logic [31:0] r1[4]    = '{10, -20, 30, -40};
    logic [31:0] r2[4]    = '{11, 22, 33, 44};
    logic [31:0] r3[4]    = '{5, 6, 7, 8};
    int cnt;

    i_rst_n = 1'b0; i_tile_start = 1'b0; i_tile_len = '0; i_first_tile = 1'b0;
    i_last_tile = 1'b0; i_psum_req = 1'b0; i_result_valid = 1'b0; i_result = '0;
`ifdef PSUM_PARITY_EN
    i_inj_parity_err = 1'b0;
`endif
    tick();
    check("rst_strobe", 32'(o_accumulation), 32'd0);
    check("rst_psum", o_psum_from_last_tile, 32'd0);
    check("rst_fvalid", 32'(o_final_valid), 32'd0);
    check("rst_fdata", o_final_data, 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    i_rst_n = 1'b1;
    tick();

    // tile chain: first -> middle -> last, then buffer must still hold tile-2 results
    run_tile(1'b1, 1'b0, zeros, r1);
    run_tile(1'b0, 1'b0, r1, r2);
    run_tile(1'b0, 1'b1, r2, r3);
    run_tile(1'b0, 1'b0, r2, r1);

    // len=64 back-to-back replays, then drain
    start_tile(64, 1'b1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      i_psum_req = 1'b1;
      tick();
      if (o_accumulation) cnt++;
    end
    i_psum_req = 1'b0;
    check("b2b_strobes", 32'(cnt), 32'd64);
    check("b2b_drain_busy", 32'(o_busy), 32'd1);
    for (int i = 0; i < 64; i++) begin
      i_result_valid = 1'b1;
      i_result       = 32'(i * 3 + 1);
      tick();
    end
    i_result_valid = 1'b0;
    check("b2b_idle", 32'(o_busy), 32'd0);
    check("b2b_err", 32'(o_err), 32'd0);
    start_tile(64, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) begin
      i_psum_req = 1'b1;
      tick();
      check("b2b_replay", o_psum_from_last_tile, 32'(i * 3 + 1));
    end
    i_psum_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      i_result_valid = 1'b1;
      i_result       = 32'(i);
      tick();
      if (o_final_valid && o_final_data == 32'(i)) cnt++;
    end
    i_result_valid = 1'b0;
    check("b2b_finals", 32'(cnt), 32'd64);
    check("b2b_err2", 32'(o_err), 32'd0);

    // start with len=0
    i_tile_start = 1'b1; i_tile_len = 7'd0; i_first_tile = 1'b1; i_last_tile = 1'b0;
    tick();
    i_tile_start = 1'b0;
    check("len0_err", 32'(o_err), 32'd1);
    check("len0_idle", 32'(o_busy), 32'd0);
    do_reset();

    // start with len > DEPTH
    i_tile_start = 1'b1; i_tile_len = 7'd65;
    tick();
    i_tile_start = 1'b0;
    check("len65_err", 32'(o_err), 32'd1);
    check("len65_idle", 32'(o_busy), 32'd0);
    do_reset();

    // fifth request on a len=4 tile
    start_tile(4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      i_psum_req = 1'b1;
      tick();
    end
    check("req4_err", 32'(o_err), 32'd0);
    tick();
    i_psum_req = 1'b0;
    check("req5_strobe", 32'(o_accumulation), 32'd0);
    check("req5_err", 32'(o_err), 32'd1);
    do_reset();

    // start while busy: ignored, original len=4 continues
    start_tile(4, 1'b1, 1'b0);
    i_tile_start = 1'b1; i_tile_len = 7'd2;
    tick();
    i_tile_start = 1'b0;
    check("restart_err", 32'(o_err), 32'd1);
    check("restart_busy", 32'(o_busy), 32'd1);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      i_psum_req = 1'b1;
      tick();
      if (o_accumulation) cnt++;
    end
    i_psum_req = 1'b0;
    check("restart_strobes", 32'(cnt), 32'd4);
    check("restart_still_busy", 32'(o_busy), 32'd1);
    do_reset();

    // write-back before any replay (hazard), and write-back in IDLE
    start_tile(4, 1'b1, 1'b0);
    i_result_valid = 1'b1; i_result = 32'd99;
    tick();
    i_result_valid = 1'b0;
    check("hazard_err", 32'(o_err), 32'd1);
    do_reset();
    i_result_valid = 1'b1;
    tick();
    i_result_valid = 1'b0;
    check("idle_wr_err", 32'(o_err), 32'd1);
    check("idle_wr_fvalid", 32'(o_final_valid), 32'd0);
    do_reset();

    // reset after 2 of 4 replays
    run_tile(1'b1, 1'b0, zeros, r1);
    start_tile(4, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      i_psum_req = 1'b1;
      tick();
      check("mid_strobe", 32'(o_accumulation), 32'd1);
      check("mid_psum", o_psum_from_last_tile, r1[i]);
    end
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_strobe", 32'(o_accumulation), 32'd0);
    check("mid_rst_psum", o_psum_from_last_tile, 32'd0);
    tick();
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_err", 32'(o_err), 32'd0);
    i_psum_req = 1'b0;
    i_rst_n    = 1'b1;
    tick();

`ifdef PSUM_PARITY_EN
    start_tile(4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      i_psum_req = 1'b1;
      tick();
      i_psum_req       = 1'b0;
      i_result_valid   = 1'b1;
      i_result         = 32'(100 + i);
      i_inj_parity_err = (i == 1);
      tick();
      i_result_valid   = 1'b0;
      i_inj_parity_err = 1'b0;
    end
    check("par_pre_err", 32'(o_err), 32'd0);
    start_tile(4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      i_psum_req = 1'b1;
      tick();
      i_psum_req = 1'b0;
      check("par_err", 32'(o_err), 32'(i >= 1));
      check("par_data", o_psum_from_last_tile, 32'(100 + i));
      i_result_valid = 1'b1;
      tick();
      i_result_valid = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
